// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: instruction-fetch controller.
// Loads the external pc register, issues one word fetch at a time,
// buffers returned words in a small FIFO and presents them to decode
// over a valid/ready handshake. Branch/jump redirects flush the buffer
// and discard any in-flight response.
// Optional feature macro: IFETCH_MISALIGN_TRAP_EN (adds fetch_misalign
// and stalls fetching after a misaligned redirect target).
module ifetch_ctrl #(
  parameter logic [31:0] RESET_VEC  = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  output logic [31:0] pc_next,
  output logic        pc_write_en,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
`ifdef IFETCH_MISALIGN_TRAP_EN
  ,
  output logic        fetch_misalign
`endif
);

  localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t        state_r;
  logic          outstanding_r;
  logic          drop_r;
  logic [AW:0]   cnt_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [31:0]   data_mem_r [FIFO_DEPTH];
  logic [31:0]   pc_mem_r   [FIFO_DEPTH];

  logic          redirect_s;
  logic [31:0]   redirect_target_s;
  logic          fetch_block_s;
  logic [AW:0]   occupancy_s;
  logic          req_s;
  logic          gnt_s;
  logic          push_s;
  logic          pop_s;

  // Redirects are ignored while the PC is still being loaded from reset.
  assign redirect_s = redirect_valid && (state_r != BOOT);

`ifdef IFETCH_MISALIGN_TRAP_EN
  logic misalign_r;

  // Raw target is loaded; a misaligned one parks the fetcher instead.
  assign redirect_target_s = redirect_pc;
  assign fetch_block_s     = misalign_r;
  assign fetch_misalign    = misalign_r;

  // Misalign flag follows the alignment of the most recent redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_r <= 1'b0;
    end else if (redirect_s) begin
      misalign_r <= (redirect_pc[1:0] != 2'b00);
    end else begin
      misalign_r <= misalign_r;
    end
  end
`else
  logic unused_redirect_lsb_s;

  // Without the trap, the low target bits are simply cleared.
  assign redirect_target_s     = {redirect_pc[31:2], 2'b00};
  assign fetch_block_s         = 1'b0;
  assign unused_redirect_lsb_s = ^redirect_pc[1:0];
`endif

  // Buffered plus in-flight words must never exceed the buffer size.
  assign occupancy_s = cnt_r + {{AW{1'b0}}, outstanding_r};
  assign req_s       = (state_r == REQ) && (occupancy_s < (AW+1)'(FIFO_DEPTH)) && !fetch_block_s;
  assign gnt_s       = req_s && imem_gnt;
  assign push_s      = (state_r == WAIT) && imem_rvalid && !drop_r && !redirect_s;
  assign pop_s       = (cnt_r != '0) && inst_ready && !redirect_s;

  assign imem_req   = req_s;
  assign imem_addr  = req_s ? pc_in : 32'h0000_0000;
  assign inst_valid = (cnt_r != '0);
  assign inst_data  = data_mem_r[rd_ptr_r];
  assign inst_pc    = pc_mem_r[rd_ptr_r];

  // PC load strobe: reset vector, then redirect, then sequential advance on grant.
  always_comb begin
    pc_write_en = 1'b0;
    pc_next     = 32'h0000_0000;
    if (rst) begin
      pc_write_en = 1'b0;
      pc_next     = 32'h0000_0000;
    end else if (state_r == BOOT) begin
      pc_write_en = 1'b1;
      pc_next     = RESET_VEC;
    end else if (redirect_s) begin
      pc_write_en = 1'b1;
      pc_next     = redirect_target_s;
    end else if (gnt_s) begin
      pc_write_en = 1'b1;
      pc_next     = pc_in + 32'd4;
    end else begin
      pc_write_en = 1'b0;
      pc_next     = 32'h0000_0000;
    end
  end

  // Fetch FSM: one outstanding request, drop flag marks a stale response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= BOOT;
      outstanding_r <= 1'b0;
      drop_r        <= 1'b0;
    end else begin
      case (state_r)
        BOOT: begin
          state_r <= REQ;
        end
        REQ: begin
          if (gnt_s) begin
            state_r       <= WAIT;
            outstanding_r <= 1'b1;
            drop_r        <= redirect_s;
          end else begin
            state_r <= REQ;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            state_r       <= REQ;
            outstanding_r <= 1'b0;
            drop_r        <= 1'b0;
          end else if (redirect_s) begin
            drop_r <= 1'b1;
          end else begin
            drop_r <= drop_r;
          end
        end
        default: begin
          state_r       <= BOOT;
          outstanding_r <= 1'b0;
          drop_r        <= 1'b0;
        end
      endcase
    end
  end

  // Instruction buffer: push from memory, pop to decode, flush on redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r    <= '0;
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_mem_r[i] <= 32'h0000_0000;
        pc_mem_r[i]   <= 32'h0000_0000;
      end
    end else if (redirect_s) begin
      cnt_r    <= '0;
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
    end else begin
      if (push_s) begin
        data_mem_r[wr_ptr_r] <= imem_rdata;
        pc_mem_r[wr_ptr_r]   <= pc_in - 32'd4;
        wr_ptr_r             <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + (AW+1)'(1);
        2'b01:   cnt_r <= cnt_r - (AW+1)'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed testbench for ifetch_ctrl with a pc register model and a
// fixed-latency instruction memory model (rdata = addr + 0x1000_0000).
`timescale 1ns/1ps
module tb_ifetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_clr = 1'b1;
  logic [31:0] pc_reg;
  logic [31:0] pc_next;
  logic        pc_write_en;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
`ifdef IFETCH_MISALIGN_TRAP_EN
  logic        fetch_misalign;
`endif

  int          tests = 0;
  int          fails = 0;
  logic        gnt_en;
  int          lat;
  logic [1:0]  sr;
  logic [31:0] a0;
  logic [31:0] a1;

  ifetch_ctrl #(.RESET_VEC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_reg), .pc_next(pc_next), .pc_write_en(pc_write_en),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc)
`ifdef IFETCH_MISALIGN_TRAP_EN
    , .fetch_misalign(fetch_misalign)
`endif
  );

  always #5 clk = ~clk;

  // Memory grants whenever enabled; response follows after lat cycles.
  assign imem_gnt    = imem_req & gnt_en;
  assign imem_rvalid = (lat == 2) ? sr[1] : sr[0];
  assign imem_rdata  = ((lat == 2) ? a1 : a0) + 32'h1000_0000;

  // Memory pipeline is independent of the DUT reset.
  always @(posedge clk or posedge mem_clr) begin
    if (mem_clr) begin
      sr <= 2'b00; a0 <= 32'h0; a1 <= 32'h0;
    end else begin
      sr <= {sr[0], imem_gnt}; a0 <= imem_addr; a1 <= a0;
    end
  end

  // External pc register model.
  always @(posedge clk or posedge rst) begin
    if (rst) pc_reg <= 32'h0000_0040;
    else if (pc_write_en) pc_reg <= pc_next;
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; gnt_en = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'h0; lat = 1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; gnt_en = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; lat = 1;
    #1;
    tests++; if (pc_write_en !== 1'b0 || pc_next !== 32'h0) begin fails++; $display("FAIL reset_pc: we=%0b next=%h exp 0/0", pc_write_en, pc_next); end
    tests++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin fails++; $display("FAIL reset_req: req=%0b addr=%h exp 0/0", imem_req, imem_addr); end
    tests++; if (inst_valid !== 1'b0 || inst_data !== 32'h0 || inst_pc !== 32'h0) begin fails++; $display("FAIL reset_inst: v=%0b d=%h pc=%h exp 0", inst_valid, inst_data, inst_pc); end
    @(negedge clk); mem_clr = 1'b0;
    @(negedge clk); rst = 1'b0; #1;
    tests++; if (pc_write_en !== 1'b1 || pc_next !== 32'h0 || imem_req !== 1'b0) begin fails++; $display("FAIL boot_load: we=%0b next=%h req=%0b exp 1/0/0", pc_write_en, pc_next, imem_req); end
    @(negedge clk); #1;
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || pc_write_en !== 1'b0) begin fails++; $display("FAIL first_req: req=%0b addr=%h we=%0b exp 1/0/0", imem_req, imem_addr, pc_write_en); end
  endtask

  task automatic test_fetch_stream();
    int n; int last; logic [31:0] exp_f;
    do_reset(); gnt_en = 1'b1; inst_ready = 1'b1;
    n = 0; last = 0; exp_f = 32'h0;
    for (int cyc = 0; cyc < 20 && n < 3; cyc++) begin
      #1;
      if (imem_req && imem_gnt) begin
        tests++;
        if (imem_addr !== exp_f || pc_write_en !== 1'b1 || pc_next !== exp_f + 32'd4) begin
          fails++; $display("FAIL stream_fetch: addr=%h next=%h exp addr=%h next=%h", imem_addr, pc_next, exp_f, exp_f + 32'd4);
        end
        exp_f = exp_f + 32'd4;
      end
      if (inst_valid) begin
        tests++;
        if (inst_pc !== 32'(n * 4) || inst_data !== 32'h1000_0000 + 32'(n * 4)) begin
          fails++; $display("FAIL stream_inst: pc=%h data=%h exp pc=%h", inst_pc, inst_data, 32'(n * 4));
        end
        if (n > 0) begin
          tests++; if (cyc - last != 2) begin fails++; $display("FAIL stream_rate: gap=%0d exp 2", cyc - last); end
        end
        last = cyc; n++;
      end
      @(negedge clk);
    end
    tests++; if (n != 3) begin fails++; $display("FAIL stream_timeout: got %0d instructions exp 3", n); end
  endtask

  task automatic test_backpressure();
    do_reset(); gnt_en = 1'b1; inst_ready = 1'b0;
    repeat (5) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      #1;
      tests++; if (imem_req !== 1'b0 || inst_valid !== 1'b1 || inst_pc !== 32'h0) begin fails++; $display("FAIL bp_full: req=%0b v=%0b pc=%h exp 0/1/0", imem_req, inst_valid, inst_pc); end
      @(negedge clk);
    end
    inst_ready = 1'b1; #1;
    tests++; if (imem_req !== 1'b0 || inst_data !== 32'h1000_0000) begin fails++; $display("FAIL bp_pop: req=%0b data=%h exp 0/10000000", imem_req, inst_data); end
    @(negedge clk); inst_ready = 1'b0; #1;
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h8 || inst_pc !== 32'h4 || inst_data !== 32'h1000_0004) begin
      fails++; $display("FAIL bp_resume: req=%0b addr=%h pc=%h data=%h exp 1/8/4/10000004", imem_req, imem_addr, inst_pc, inst_data);
    end
  endtask

  task automatic test_redirect_wait();
    logic found;
    do_reset(); lat = 2; gnt_en = 1'b1; inst_ready = 1'b1;
    repeat (7) @(negedge clk);
    inst_ready = 1'b0;
    @(negedge clk); #1;
    tests++; if (imem_req !== 1'b0 || inst_valid !== 1'b1 || inst_pc !== 32'h4) begin fails++; $display("FAIL rw_pre: req=%0b v=%0b pc=%h exp 0/1/4", imem_req, inst_valid, inst_pc); end
    redirect_valid = 1'b1; redirect_pc = 32'h100; #1;
    tests++; if (pc_write_en !== 1'b1 || pc_next !== 32'h100) begin fails++; $display("FAIL rw_load: we=%0b next=%h exp 1/100", pc_write_en, pc_next); end
    @(negedge clk); redirect_valid = 1'b0; #1;
    tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL rw_flush: v=%0b exp 0", inst_valid); end
    @(negedge clk); #1;
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || inst_valid !== 1'b0) begin fails++; $display("FAIL rw_refetch: req=%0b addr=%h v=%0b exp 1/100/0", imem_req, imem_addr, inst_valid); end
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin @(negedge clk); #1; if (inst_valid) found = 1'b1; end
    tests++;
    if (!found) begin fails++; $display("FAIL rw_timeout: no instruction after redirect"); end
    else if (inst_pc !== 32'h100 || inst_data !== 32'h1000_0100) begin fails++; $display("FAIL rw_inst: pc=%h data=%h exp 100/10000100", inst_pc, inst_data); end
  endtask

  task automatic test_redirect_gnt();
    logic found;
    do_reset(); gnt_en = 1'b1;
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h200; #1;
    tests++; if (imem_gnt !== 1'b1 || pc_write_en !== 1'b1 || pc_next !== 32'h200) begin fails++; $display("FAIL rg_load: gnt=%0b we=%0b next=%h exp 1/1/200", imem_gnt, pc_write_en, pc_next); end
    @(negedge clk); redirect_valid = 1'b0; #1;
    tests++; if (imem_req !== 1'b0 || pc_write_en !== 1'b0) begin fails++; $display("FAIL rg_wait: req=%0b we=%0b exp 0/0", imem_req, pc_write_en); end
    @(negedge clk); #1;
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h200 || inst_valid !== 1'b0) begin fails++; $display("FAIL rg_refetch: req=%0b addr=%h v=%0b exp 1/200/0", imem_req, imem_addr, inst_valid); end
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin @(negedge clk); #1; if (inst_valid) found = 1'b1; end
    tests++;
    if (!found) begin fails++; $display("FAIL rg_timeout: no instruction after redirect"); end
    else if (inst_pc !== 32'h200 || inst_data !== 32'h1000_0200) begin fails++; $display("FAIL rg_inst: pc=%h data=%h exp 200/10000200", inst_pc, inst_data); end
  endtask

  task automatic test_wrap();
    do_reset();
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
    tests++; if (pc_write_en !== 1'b1 || pc_next !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_redir: we=%0b next=%h exp 1/fffffffc", pc_write_en, pc_next); end
    @(negedge clk); redirect_valid = 1'b0; gnt_en = 1'b1; #1;
    tests++; if (imem_addr !== 32'hFFFF_FFFC || pc_write_en !== 1'b1 || pc_next !== 32'h0) begin fails++; $display("FAIL wrap_next: addr=%h we=%0b next=%h exp fffffffc/1/0", imem_addr, pc_write_en, pc_next); end
    @(negedge clk); @(negedge clk); #1;
    tests++; if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC || inst_data !== 32'h0FFF_FFFC) begin fails++; $display("FAIL wrap_inst: v=%0b pc=%h data=%h exp 1/fffffffc/0ffffffc", inst_valid, inst_pc, inst_data); end
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin fails++; $display("FAIL wrap_addr: req=%0b addr=%h exp 1/0", imem_req, imem_addr); end
  endtask

  task automatic test_misalign();
    do_reset();
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h102; #1;
`ifdef IFETCH_MISALIGN_TRAP_EN
    tests++; if (pc_write_en !== 1'b1 || pc_next !== 32'h102) begin fails++; $display("FAIL mis_load: we=%0b next=%h exp 1/102", pc_write_en, pc_next); end
    @(negedge clk); redirect_valid = 1'b0; gnt_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests++; if (fetch_misalign !== 1'b1 || imem_req !== 1'b0) begin fails++; $display("FAIL mis_stall: flag=%0b req=%0b exp 1/0", fetch_misalign, imem_req); end
      @(negedge clk);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h200; #1;
    tests++; if (pc_next !== 32'h200) begin fails++; $display("FAIL mis_clear_load: next=%h exp 200", pc_next); end
    @(negedge clk); redirect_valid = 1'b0; #1;
    tests++; if (fetch_misalign !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin fails++; $display("FAIL mis_resume: flag=%0b req=%0b addr=%h exp 0/1/200", fetch_misalign, imem_req, imem_addr); end
`else
    tests++; if (pc_write_en !== 1'b1 || pc_next !== 32'h100) begin fails++; $display("FAIL mis_align: we=%0b next=%h exp 1/100", pc_write_en, pc_next); end
    @(negedge clk); redirect_valid = 1'b0; #1;
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin fails++; $display("FAIL mis_fetch: req=%0b addr=%h exp 1/100", imem_req, imem_addr); end
`endif
  endtask

  task automatic test_reset_midfetch();
    do_reset(); lat = 2; gnt_en = 1'b1;
    @(negedge clk); #1;
    tests++; if (imem_gnt !== 1'b1 || imem_addr !== 32'h0) begin fails++; $display("FAIL mid_gnt: gnt=%0b addr=%h exp 1/0", imem_gnt, imem_addr); end
    @(negedge clk); gnt_en = 1'b0; rst = 1'b1; #1;
    tests++; if (imem_req !== 1'b0 || pc_write_en !== 1'b0 || inst_valid !== 1'b0) begin fails++; $display("FAIL mid_rst: req=%0b we=%0b v=%0b exp 0/0/0", imem_req, pc_write_en, inst_valid); end
    @(negedge clk); rst = 1'b0; #1;
    tests++; if (pc_write_en !== 1'b1 || pc_next !== 32'h0) begin fails++; $display("FAIL mid_boot: we=%0b next=%h exp 1/0", pc_write_en, pc_next); end
    @(negedge clk); #1;
    tests++; if (inst_valid !== 1'b0 || imem_req !== 1'b1) begin fails++; $display("FAIL mid_late: v=%0b req=%0b exp 0/1", inst_valid, imem_req); end
  endtask

  initial begin
    gnt_en = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; lat = 1;
    test_reset();
    test_fetch_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_gnt();
    test_wrap();
    test_misalign();
    test_reset_midfetch();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ifetch_ctrl.md
Name: ifetch_ctrl

Overview:
- Instruction-fetch controller that sits on the far side of the `pc` register.
- Drives `pc_next` and `pc_write_en` into the `pc` register and reads the current PC back from it.
- Issues word fetches to instruction memory and buffers the returned instructions in a small FIFO.
- Presents instructions to decode over a valid/ready handshake; handles branch/jump redirects by flushing.

Parameters:
- RESET_VEC, 32'h0000_0000: value driven on `pc_next` with `pc_write_en` high in the first cycle after reset; no fetch is issued before this load.
- FIFO_DEPTH, 2: instruction buffer entries; must be a power of 2 and at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- pc_in  in  32  current PC, taken from `pc.pc_out`.
- pc_next  out  32  next PC into the `pc` register.
- pc_write_en  out  1  PC load strobe into the `pc` register.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; always equals `pc_in` while `imem_req` is high.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  32  instruction word.
- redirect_valid  in  1  single-cycle redirect request (branch or jump).
- redirect_pc  in  32  redirect target.
- inst_valid  out  1  buffer head is valid.
- inst_ready  in  1  decode accepts the buffer head.
- inst_data  out  32  instruction at the buffer head.
- inst_pc  out  32  PC of the instruction at the buffer head.

Behaviour:
- Reset (asynchronous, active-high):
  - state = BOOT; FIFO empty; outstanding = 0; drop = 0.
  - All outputs 0.
- BOOT (one cycle after `rst` deasserts):
  - Drive `pc_write_en`=1 and `pc_next`=RESET_VEC.
  - Go to REQ. The first `imem_req` appears on the following cycle, once `pc_in` = RESET_VEC.
- REQ:
  - `imem_req`=1 only when (FIFO count + outstanding) < FIFO_DEPTH; otherwise hold `imem_req`=0 and stay in REQ.
  - Once raised, `imem_req` and `imem_addr` stay stable until `imem_gnt`.
  - On `imem_gnt`: `pc_write_en`=1, `pc_next`=`pc_in`+4 (mod 2^32, wraps from 32'hFFFF_FFFC to 0), outstanding=1, go to WAIT.
- WAIT:
  - `imem_req`=0; only one fetch is ever outstanding.
  - On `imem_rvalid`: if drop=0, push {`pc_in`-4, `imem_rdata`} into the FIFO; clear outstanding and drop; go to REQ.
  - An `imem_rvalid` arriving while in REQ is ignored.
- Output side:
  - `inst_valid` = FIFO not empty; `inst_data`/`inst_pc` come from the head entry (registered FIFO, zero extra latency).
  - Pop when `inst_valid` && `inst_ready`.
  - Push and pop may occur in the same cycle.
  - Gating guarantees no push into a full FIFO.
- Redirect (highest priority, any state except BOOT):
  - `pc_write_en`=1, `pc_next`=`redirect_pc`; FIFO flushed (count=0, no pop counted); `inst_valid`=0 from the next cycle.
  - In REQ without `imem_gnt`: the request is withdrawn and re-issued next cycle at the new PC.
  - Same cycle as `imem_gnt`: that fetch becomes outstanding with drop=1, and state goes to WAIT.
  - In WAIT: drop=1. An `imem_rvalid` in the same cycle as the redirect is discarded.
  - The discarded response returns to REQ as usual.
- Throughput: with `imem_rvalid` one cycle after `imem_gnt`, one instruction every 2 cycles.
- `rst` asserted mid-fetch: all state cleared immediately; a late `imem_rvalid` after reset is ignored because the block is in BOOT/REQ.

Optional Feature:
- Macro: IFETCH_MISALIGN_TRAP_EN.
- Defined:
  - Adds output `fetch_misalign` (1 bit). It is set when `redirect_valid` arrives with `redirect_pc[1:0]` != 0.
  - While it is set, `imem_req` is held at 0 and no fetches are issued.
  - It is cleared by the next aligned redirect, which loads the PC normally.
- Undefined: `redirect_pc[1:0]` is forced to 00 before it drives `pc_next`; the `fetch_misalign` port is absent.

Test Plan:
- Reset release, memory grants immediately and `imem_rvalid` follows one cycle later → `pc_write_en` with `pc_next`=0; fetches at 0, 4, 8; `inst_pc`=0, 4, 8 carrying the matching `imem_rdata`.
- `inst_ready`=0 with FIFO_DEPTH=2 → two entries buffered; `imem_req` stays 0 until the first pop.
- Redirect to 32'h100 while a fetch of 32'h8 is in WAIT → the 32'h8 response is dropped; next `inst_pc`=32'h100; FIFO empty in the cycle after the redirect.
- Redirect in the same cycle as `imem_gnt` → `pc_next`=redirect target, not `pc_in`+4; the granted response is discarded.
- PC at 32'hFFFF_FFFC granted → `pc_next`=0.
- Redirect to 32'h102: with macro defined → `fetch_misalign`=1 and no requests until a redirect to 32'h200; without the macro → fetch issued at 32'h100.
